// File: rtl/lzrw1_decomp_sequencer_if.sv
// Handshake bundle between the LZRW1 stream sequencer and its environment.
//   Stream side     : in_data / in_valid / in_last carry compressed 16-bit words
//                     towards the sequencer; in_ready signals acceptance.
//   Decompressor side: dec_data_in / dec_control_word_in / dec_data_in_valid
//                     present one item to decompressor_top; dec_busy is its
//                     busy indication.
// Modports:
//   master : the sequencer (consumes the stream, drives the decompressor).
//   slave  : the environment (stream source plus decompressor).
interface lzrw1_decomp_sequencer_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] dec_data_in;
  logic        dec_control_word_in;
  logic        dec_data_in_valid;
  logic        dec_busy;

  modport master (
    input  in_data, in_valid, in_last, dec_busy,
    output in_ready, dec_data_in, dec_control_word_in, dec_data_in_valid
  );

  modport slave (
    output in_data, in_valid, in_last, dec_busy,
    input  in_ready, dec_data_in, dec_control_word_in, dec_data_in_valid
  );
endinterface

// File: rtl/lzrw1_decomp_sequencer.sv
// LZRW1 decompression stream sequencer.
// Splits the compressed stream (a control word followed by up to GROUP_SIZE
// item words) into single items, attaches each item's copy/literal flag taken
// LSB-first from the control word, and hands them to decompressor_top one at a
// time. Tracks group boundaries and end of stream, and reports completion,
// protocol error and the number of accepted items.
// Ports:
//   clock, reset (async, active-low), start (one-cycle stream start pulse)
//   sif        : stream input and decompressor output handshake (master side)
//   busy       : stream in progress
//   done       : one-cycle end-of-stream pulse
//   error      : sticky, in_last seen on a control-word slot; cleared by start
//   item_count : items accepted by the decompressor, saturating
module lzrw1_decomp_sequencer #(
  parameter int GROUP_SIZE  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  lzrw1_decomp_sequencer_if.master sif,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] item_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_CW, S_FETCH_ITEM, S_ISSUE, S_GUARD, S_WAIT_BUSY, S_DONE
  } state_t;

  localparam logic [3:0] K_LAST = 4'(GROUP_SIZE - 1);

  state_t                 state_q, state_d;
  logic [15:0]            cw_q, cw_d;
  logic [3:0]             k_q, k_d;
  logic                   last_q, last_d;
  logic                   error_q, error_d;
  logic [15:0]            dec_data_q, dec_data_d;
  logic                   dec_flag_q, dec_flag_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + COUNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cw_q       <= '0;
      k_q        <= '0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
      dec_data_q <= '0;
      dec_flag_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cw_q       <= cw_d;
      k_q        <= k_d;
      last_q     <= last_d;
      error_q    <= error_d;
      dec_data_q <= dec_data_d;
      dec_flag_q <= dec_flag_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start) state_d = S_FETCH_CW;
      S_FETCH_CW:   if (sif.in_valid) state_d = sif.in_last ? S_DONE : S_FETCH_ITEM;
      S_FETCH_ITEM: if (sif.in_valid) state_d = S_ISSUE;
      S_ISSUE:      if (!sif.dec_busy) state_d = S_GUARD;
      // One dead cycle gives the decompressor time to raise dec_busy.
      S_GUARD:      state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!sif.dec_busy) begin
          if (last_q)              state_d = S_DONE;
          else if (k_q == K_LAST)  state_d = S_FETCH_CW;
          else                     state_d = S_FETCH_ITEM;
        end
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cw_d       = cw_q;
    k_d        = k_q;
    last_d     = last_q;
    error_d    = error_q;
    dec_data_d = dec_data_q;
    dec_flag_d = dec_flag_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          error_d = 1'b0;
          k_d     = '0;
          last_d  = 1'b0;
        end
      end
      S_FETCH_CW: begin
        if (sif.in_valid) begin
          // Unused high bits of a short group are zero-filled and never indexed.
          cw_d = 16'(sif.in_data[GROUP_SIZE-1:0]);
          k_d  = '0;
          if (sif.in_last) error_d = 1'b1;
        end
      end
      S_FETCH_ITEM: begin
        if (sif.in_valid) begin
          dec_data_d = sif.in_data;
          dec_flag_d = cw_q[k_q];
          last_d     = sif.in_last;
        end
      end
      S_ISSUE: begin
        if (!sif.dec_busy) count_d = sat_inc(count_q);
      end
      S_WAIT_BUSY: begin
        if (!sif.dec_busy && !last_q && (k_q != K_LAST)) k_d = k_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Every control output is a pure decode of the state register.
  always_comb begin
    sif.in_ready          = (state_q == S_FETCH_CW) || (state_q == S_FETCH_ITEM);
    sif.dec_data_in_valid = (state_q == S_ISSUE);
    busy                  = (state_q != S_IDLE);
    done                  = (state_q == S_DONE);
  end

  assign sif.dec_data_in         = dec_data_q;
  assign sif.dec_control_word_in = dec_flag_q;
  assign error                   = error_q;
  assign item_count              = count_q;

endmodule
